find_k_peaks: RTL and testbench

Parametrised top-K spectral peak finder. It runs a pipelined max tree over a configurable-width magnitude frame for K rounds and masks each winner before the next round. It sits between the FFT magnitude stage and the fingerprint hasher, and emits up to K_PEAKS (magnitude, index) pairs per frame in descending order. Indices travel as a separate field alongside each candidate; they are no longer packed into the data word.

---
 rtl/peak_pkg.sv | 36 +++
 rtl/peak_max_tree.sv | 37 +++
 rtl/find_k_peaks.sv | 169 ++++++++++++++++
 tb/tb_find_k_peaks.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Shared types and helpers for the top-K spectral peak finder.
// Candidate widths are sized for the default frame; smaller frames zero-extend into them.
package peak_pkg;

   localparam int N_BINS_DEF          = 512;
   localparam int MAG_W_DEF           = 16;
   localparam int K_PEAKS_DEF         = 4;
   localparam int SUPPRESS_RADIUS_DEF = 2;

   localparam int CAND_MAG_W = MAG_W_DEF;
   localparam int CAND_IDX_W = $clog2(N_BINS_DEF);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_EMIT
   } state_t;

   typedef struct packed {
      logic                  eligible;
      logic [CAND_MAG_W-1:0] mag;
      logic [CAND_IDX_W-1:0] idx;
   } candidate_t;

   // Eligible beats ineligible, then larger magnitude, then lower bin index.
   function automatic candidate_t better(input candidate_t a, input candidate_t b);
      if (a.eligible != b.eligible) begin
         return a.eligible ? a : b;
      end
      if (a.mag != b.mag) begin
         return (a.mag > b.mag) ? a : b;
      end
      return (a.idx <= b.idx) ? a : b;
   endfunction

endpackage

// File: rtl/peak_max_tree.sv
// Registered max-reduction tree: N_BINS candidates in, best candidate out $clog2(N_BINS) cycles later.
// Nodes are laid out heap-style; node j has children 2j+1 and 2j+2, leaves follow the last node.
module peak_max_tree
   import peak_pkg::*;
#(
   parameter int N_BINS = N_BINS_DEF
)(
   input  logic                         clk,
   input  candidate_t [N_BINS-1:0]      cand_i,
   output candidate_t                   win_o
);

   localparam int N_NODE = N_BINS - 1;

   candidate_t node_d [N_NODE];
   candidate_t node_q [N_NODE];

   for (genvar j = 0; j < N_NODE; j++) begin : g_node
      candidate_t lhs;
      candidate_t rhs;
      if (2*j + 2 < N_NODE) begin : g_inner
         assign lhs = node_q[2*j + 1];
         assign rhs = node_q[2*j + 2];
      end else begin : g_leaf
         assign lhs = cand_i[2*j + 1 - N_NODE];
         assign rhs = cand_i[2*j + 2 - N_NODE];
      end
      assign node_d[j] = better(lhs, rhs);
   end

   always_ff @(posedge clk) begin
      node_q <= node_d;
   end

   assign win_o = node_q[0];

endmodule

// File: rtl/find_k_peaks.sv
// Top-K peak finder: K rounds of max-tree search over a captured frame, masking each winner.
// Optional macro PEAK_NEIGHBOR_SUPPRESS_EN also masks SUPPRESS_RADIUS bins either side of a winner.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; frame and mask are idle
// ST_SEARCH | frame and mask feeding the tree; timer counts down L cycles
// ST_EMIT   | tree root is fresh; report winner or end the frame
module find_k_peaks
   import peak_pkg::*;
#(
   parameter  int N_BINS          = N_BINS_DEF,
   parameter  int MAG_W           = MAG_W_DEF,
   parameter  int K_PEAKS         = K_PEAKS_DEF,
   parameter  int SUPPRESS_RADIUS = SUPPRESS_RADIUS_DEF,
   localparam int L               = $clog2(N_BINS),
   localparam int RANK_W          = $clog2(K_PEAKS) + 1
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [N_BINS*MAG_W-1:0]   data_in,
   output logic                      busy,
   output logic                      peak_valid,
   output logic [MAG_W-1:0]          peak_mag,
   output logic [L-1:0]              peak_index,
   output logic [RANK_W-1:0]         peak_rank,
   output logic                      done
);

`ifdef PEAK_NEIGHBOR_SUPPRESS_EN
   localparam bit SUPPRESS_ON = 1'b1;
`else
   localparam bit SUPPRESS_ON = 1'b0;
`endif
   localparam int RADIUS = SUPPRESS_ON ? SUPPRESS_RADIUS : 0;
   localparam int TMR_W  = $clog2(L + 1);

   state_t                     state_q, state_d;
   logic [N_BINS*MAG_W-1:0]    frame_q, frame_d;
   logic [N_BINS-1:0]          mask_q, mask_d;
   logic [RANK_W-1:0]          rnd_q, rnd_d;
   logic [TMR_W-1:0]           tmr_q, tmr_d;
   logic                       pv_q, pv_d;
   logic                       done_q, done_d;
   logic [MAG_W-1:0]           mag_q, mag_d;
   logic [L-1:0]               idx_q, idx_d;
   logic [RANK_W-1:0]          rank_q, rank_d;

   candidate_t [N_BINS-1:0]    leaf;
   candidate_t                 win;
   logic [MAG_W-1:0]           win_mag;
   logic [L-1:0]               win_idx;

   for (genvar i = 0; i < N_BINS; i++) begin : g_leaf
      assign leaf[i] = '{eligible: mask_q[i],
                         mag:      CAND_MAG_W'(frame_q[i*MAG_W +: MAG_W]),
                         idx:      CAND_IDX_W'(i)};
   end

   peak_max_tree #(
      .N_BINS (N_BINS)
   ) u_tree (
      .clk    (clk),
      .cand_i (leaf),
      .win_o  (win)
   );

   assign win_mag = MAG_W'(win.mag);
   assign win_idx = L'(win.idx);

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      mask_d  = mask_q;
      rnd_d   = rnd_q;
      tmr_d   = tmr_q;
      pv_d    = 1'b0;
      done_d  = 1'b0;
      mag_d   = mag_q;
      idx_d   = idx_q;
      rank_d  = rank_q;

      case (state_q)
         ST_IDLE: begin
            // done_q still high means busy is still asserted this cycle
            if (start && !done_q) begin
               frame_d = data_in;
               mask_d  = '1;
               rnd_d   = '0;
               tmr_d   = TMR_W'(L - 1);
               state_d = ST_SEARCH;
            end
         end

         ST_SEARCH: begin
            if (tmr_q == '0) begin
               state_d = ST_EMIT;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end

         ST_EMIT: begin
            if (win.eligible) begin
               mag_d  = win_mag;
               idx_d  = win_idx;
               rank_d = rnd_q;
               pv_d   = 1'b1;
               rnd_d  = rnd_q + 1'b1;
               // RADIUS is zero unless neighbour suppression is compiled in
               for (int i = 0; i < N_BINS; i++) begin
                  if ((i + RADIUS >= int'(win_idx)) && (i <= int'(win_idx) + RADIUS)) begin
                     mask_d[i] = 1'b0;
                  end
               end
               if (rnd_q == RANK_W'(K_PEAKS - 1)) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmr_d   = TMR_W'(L - 1);
                  state_d = ST_SEARCH;
               end
            end else begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         frame_q <= '0;
         mask_q  <= '1;
         rnd_q   <= '0;
         tmr_q   <= '0;
         pv_q    <= 1'b0;
         done_q  <= 1'b0;
         mag_q   <= '0;
         idx_q   <= '0;
         rank_q  <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         mask_q  <= mask_d;
         rnd_q   <= rnd_d;
         tmr_q   <= tmr_d;
         pv_q    <= pv_d;
         done_q  <= done_d;
         mag_q   <= mag_d;
         idx_q   <= idx_d;
         rank_q  <= rank_d;
      end
   end

   assign busy       = (state_q != ST_IDLE) || done_q;
   assign peak_valid = pv_q;
   assign done       = done_q;
   assign peak_mag   = mag_q;
   assign peak_index = idx_q;
   assign peak_rank  = rank_q;

endmodule

// File: tb/tb_find_k_peaks.sv
// Bench for find_k_peaks: table of frames with expected peaks, scoreboard-checked outputs,
// plus hand sequences for ignored start, mid-frame reset and early termination on a 4-bin instance.
module tb_find_k_peaks;

   localparam int NB = 512;
   localparam int MW = 16;
   localparam int KP = 4;
   localparam int LB = 9;
   localparam int RW = 3;
   localparam int NS = 4;
   localparam int KS = 8;
   localparam int RS = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [NB*MW-1:0]  data_in = '0;
   logic              busy, peak_valid, done;
   logic [MW-1:0]     peak_mag;
   logic [LB-1:0]     peak_index;
   logic [RW-1:0]     peak_rank;

   logic              start_s = 1'b0;
   logic [NS*MW-1:0]  data_s = '0;
   logic              busy_s, peak_valid_s, done_s;
   logic [MW-1:0]     peak_mag_s;
   logic [1:0]        peak_index_s;
   logic [RS-1:0]     peak_rank_s;

   find_k_peaks dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in),
      .busy(busy), .peak_valid(peak_valid), .peak_mag(peak_mag),
      .peak_index(peak_index), .peak_rank(peak_rank), .done(done)
   );

   find_k_peaks #(.N_BINS(NS), .MAG_W(MW), .K_PEAKS(KS), .SUPPRESS_RADIUS(2)) dut_s (
      .clk(clk), .reset(reset), .start(start_s), .data_in(data_s),
      .busy(busy_s), .peak_valid(peak_valid_s), .peak_mag(peak_mag_s),
      .peak_index(peak_index_s), .peak_rank(peak_rank_s), .done(done_s)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      int          cyc;
      logic        valid;
      logic        dn;
      logic [15:0] mag;
      int          idx;
      int          rank;
   } exp_t;

   typedef struct packed {
      int               bin_a;
      logic [15:0]      mag_a;
      int               bin_b;
      logic [15:0]      mag_b;
      logic [15:0]      bg;
      logic [3:0][15:0] exp_mag;
      logic [3:0][8:0]  exp_idx;
   } vec_t;

   exp_t sb[$];
   exp_t sb_s[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(int ba, int ma, int bb, int mb, int bg,
                               int m0, int x0, int m1, int x1,
                               int m2, int x2, int m3, int x3);
      vec_t v;
      v.bin_a = ba;  v.mag_a = 16'(ma);
      v.bin_b = bb;  v.mag_b = 16'(mb);
      v.bg    = 16'(bg);
      v.exp_mag[0] = 16'(m0); v.exp_idx[0] = 9'(x0);
      v.exp_mag[1] = 16'(m1); v.exp_idx[1] = 9'(x1);
      v.exp_mag[2] = 16'(m2); v.exp_idx[2] = 9'(x2);
      v.exp_mag[3] = 16'(m3); v.exp_idx[3] = 9'(x3);
      return v;
   endfunction

   function automatic logic [NB*MW-1:0] build_frame(vec_t v);
      logic [NB*MW-1:0] f;
      for (int i = 0; i < NB; i++) f[i*MW +: MW] = v.bg;
      f[v.bin_a*MW +: MW] = v.mag_a;
      f[v.bin_b*MW +: MW] = v.mag_b;
      return f;
   endfunction

   task automatic push_frame(input vec_t v, input int e0, input int n_rounds);
      for (int r = 0; r < n_rounds; r++) begin
         sb.push_back('{cyc: e0 + (r + 1) * (LB + 1), valid: 1'b1, dn: (r == KP - 1),
                        mag: v.exp_mag[r], idx: int'(v.exp_idx[r]), rank: r});
      end
   endtask

   // Called at a negedge; start is sampled at the next posedge.
   task automatic start_main(input logic [NB*MW-1:0] f);
      data_in = f;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      data_in = '0;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (peak_valid || done) begin
         if (sb.size() == 0) begin
            chk("main_unexpected_event", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("main_cycle", cyc, e.cyc);
            chk("main_valid", peak_valid, e.valid);
            chk("main_done", done, e.dn);
            if (e.valid) begin
               chk("main_mag", peak_mag, e.mag);
               chk("main_idx", peak_index, e.idx);
               chk("main_rank", peak_rank, e.rank);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (peak_valid_s || done_s) begin
         if (sb_s.size() == 0) begin
            chk("small_unexpected_event", 1, 0);
         end else begin
            exp_t e;
            e = sb_s.pop_front();
            chk("small_cycle", cyc, e.cyc);
            chk("small_valid", peak_valid_s, e.valid);
            chk("small_done", done_s, e.dn);
            if (e.valid) begin
               chk("small_mag", peak_mag_s, e.mag);
               chk("small_idx", peak_index_s, e.idx);
               chk("small_rank", peak_rank_s, e.rank);
            end
         end
      end
   end

   vec_t tbl [5];

   initial begin
      int e0;
      int small_end;

`ifdef PEAK_NEIGHBOR_SUPPRESS_EN
      tbl[0] = mk( 37, 100,  37, 100, 0,      100, 37,     0, 0,     0, 3,     0, 6);
      tbl[1] = mk( 10, 'hFFFF, 400, 'hFFFF, 0, 'hFFFF, 10, 'hFFFF, 400, 0, 0,  0, 3);
      tbl[2] = mk(511, 5,    0,   5,   0,      5, 0,        5, 511,   0, 3,     0, 6);
      tbl[3] = mk(200, 3,    201, 2,   1,      3, 200,      1, 0,     1, 3,     1, 6);
      tbl[4] = mk(  0, 'hFFFF, 0, 'hFFFF, 'hFFFF, 'hFFFF, 0, 'hFFFF, 3, 'hFFFF, 6, 'hFFFF, 9);
`else
      tbl[0] = mk( 37, 100,  37, 100, 0,      100, 37,     0, 0,     0, 1,     0, 2);
      tbl[1] = mk( 10, 'hFFFF, 400, 'hFFFF, 0, 'hFFFF, 10, 'hFFFF, 400, 0, 0,  0, 1);
      tbl[2] = mk(511, 5,    0,   5,   0,      5, 0,        5, 511,   0, 1,     0, 2);
      tbl[3] = mk(200, 3,    201, 2,   1,      3, 200,      2, 201,   1, 0,     1, 1);
      tbl[4] = mk(  0, 'hFFFF, 0, 'hFFFF, 'hFFFF, 'hFFFF, 0, 'hFFFF, 1, 'hFFFF, 2, 'hFFFF, 3);
`endif

      // start held together with reset must be ignored
      reset   = 1'b1;
      start   = 1'b1;
      data_in = build_frame(tbl[0]);
      start_s = 1'b1;
      data_s  = {16'd1, 16'd7, 16'd7, 16'd3};
      repeat (3) @(negedge clk);
      reset   = 1'b0;
      start   = 1'b0;
      start_s = 1'b0;
      data_in = '0;
      chk("reset_busy", busy, 0);
      chk("reset_valid", peak_valid, 0);
      chk("reset_done", done, 0);
      chk("reset_mag", peak_mag, 0);
      chk("reset_idx", peak_index, 0);
      chk("reset_rank", peak_rank, 0);
      @(negedge clk);
      chk("start_in_reset_ignored", busy, 0);
      chk("start_in_reset_ignored_small", busy_s, 0);

      // back-to-back frames: each start lands in the first busy-low cycle
      for (int t = 0; t < 5; t++) begin
         e0 = cyc + 1;
         push_frame(tbl[t], e0, KP);
         start_main(build_frame(tbl[t]));
         wait_to(e0 + 40);
         chk("busy_in_done_cycle", busy, 1);
         @(negedge clk);
         chk("busy_low_after_done", busy, 0);
         chk("mag_held", peak_mag, tbl[t].exp_mag[3]);
         chk("idx_held", peak_index, tbl[t].exp_idx[3]);
      end

      // second start mid-frame is ignored
      e0 = cyc + 1;
      push_frame(tbl[0], e0, KP);
      start_main(build_frame(tbl[0]));
      wait_to(e0 + 4);
      data_in = build_frame(tbl[1]);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      data_in = '0;
      wait_to(e0 + 40);
      chk("ignore_busy_e40", busy, 1);
      @(negedge clk);
      chk("ignore_busy_e41", busy, 0);

      // reset mid-frame aborts after the rank-0 peak
      e0 = cyc + 1;
      push_frame(tbl[0], e0, 1);
      start_main(build_frame(tbl[0]));
      wait_to(e0 + 14);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_mag", peak_mag, 0);
      chk("abort_idx", peak_index, 0);
      chk("abort_rank", peak_rank, 0);
      @(negedge clk);
      chk("abort_busy_e16", busy, 0);
      repeat (50) @(negedge clk);
      chk("abort_no_more_events", sb.size(), 0);

      e0 = cyc + 1;
      push_frame(tbl[3], e0, KP);
      start_main(build_frame(tbl[3]));
      wait_to(e0 + 41);
      chk("restart_busy_low", busy, 0);

      // 4-bin instance, K=8: early termination once every bin is masked
      e0 = cyc + 1;
`ifdef PEAK_NEIGHBOR_SUPPRESS_EN
      sb_s.push_back('{cyc: e0 + 3, valid: 1'b1, dn: 1'b0, mag: 16'd7, idx: 1, rank: 0});
      sb_s.push_back('{cyc: e0 + 6, valid: 1'b0, dn: 1'b1, mag: 16'd0, idx: 0, rank: 0});
      small_end = e0 + 6;
`else
      sb_s.push_back('{cyc: e0 + 3,  valid: 1'b1, dn: 1'b0, mag: 16'd7, idx: 1, rank: 0});
      sb_s.push_back('{cyc: e0 + 6,  valid: 1'b1, dn: 1'b0, mag: 16'd7, idx: 2, rank: 1});
      sb_s.push_back('{cyc: e0 + 9,  valid: 1'b1, dn: 1'b0, mag: 16'd3, idx: 0, rank: 2});
      sb_s.push_back('{cyc: e0 + 12, valid: 1'b1, dn: 1'b0, mag: 16'd1, idx: 3, rank: 3});
      sb_s.push_back('{cyc: e0 + 15, valid: 1'b0, dn: 1'b1, mag: 16'd0, idx: 0, rank: 0});
      small_end = e0 + 15;
`endif
      data_s  = {16'd1, 16'd7, 16'd7, 16'd3};
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      data_s  = '0;
      wait_to(small_end);
      chk("small_busy_done_cycle", busy_s, 1);
      @(negedge clk);
      chk("small_busy_low", busy_s, 0);

      repeat (5) @(negedge clk);
      chk("main_queue_drained", sb.size(), 0);
      chk("small_queue_drained", sb_s.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
